uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have the parameter CLK_FREQ, default 12_000_000, giving the clock frequency in Hz.
REQ-002 The block SHALL have the parameter BAUD, default 115_200, giving the line rate in bit/s.
REQ-003 The block SHALL have the parameter DATA_BITS, default 8, giving the payload width; legal range is 5..9.
REQ-004 The block SHALL have the parameter PARITY, default PAR_NONE: PAR_NONE, PAR_EVEN or PAR_ODD.
REQ-005 The block SHALL have the parameter STOP_BITS, default 1; legal values are 1 and 2.
REQ-006 The block SHALL have the parameter FIFO_DEPTH, default 16; it must be a power of two, 2..256.
REQ-007 Port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-008 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 Port data, input, DATA_BITS wide: the byte to queue.
REQ-010 Port send, input, 1 bit: write strobe; data is accepted on an edge where send and ready are both 1.
REQ-011 Port ready, output, 1 bit: 1 when the FIFO is not full.
REQ-012 Port uart_tx, output, 1 bit: registered serial line; it idles high.
REQ-013 Port busy, output, 1 bit: 1 while a frame is on the line or the FIFO is non-empty.
REQ-014 Port overflow, output, 1 bit: one-cycle pulse when send=1 while ready=0.
REQ-015 Port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 CLKS_PER_BIT SHALL equal (CLK_FREQ + BAUD/2) / BAUD, using integer rounding; the default gives 104.
REQ-017 A write while full SHALL be dropped, SHALL leave FIFO contents unchanged, and SHALL pulse overflow on the following cycle.
REQ-018 The FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
REQ-019 In IDLE with the FIFO non-empty, the block SHALL pop one word and enter START on that edge; uart_tx SHALL go low on the same edge.
REQ-020 Latency SHALL be as follows: a write accepted at edge N into an idle, empty block drives uart_tx low at edge N+1.
REQ-021 Every line bit SHALL last exactly CLKS_PER_BIT cycles, counted by an internal bit-period counter reloaded at each bit boundary.
REQ-022 DATA SHALL shift the popped word out LSB first, for DATA_BITS bits.
REQ-023 PARITY SHALL be skipped when PARITY=PAR_NONE; otherwise the bit sent SHALL be the XOR of the data bits (even parity) or its inverse (odd parity).
REQ-024 STOP SHALL drive 1 for STOP_BITS × CLKS_PER_BIT cycles.
REQ-025 At the end of STOP, the block SHALL pop the next word and enter START when the FIFO is non-empty, with no idle gap; otherwise it SHALL enter IDLE.
REQ-026 A write and an internal pop on the same edge SHALL both take effect, leaving fifo_count unchanged; a write while full SHALL never be accepted, even on a pop edge, because ready is registered from the count before that edge.
REQ-027 fifo_count SHALL never wrap; the read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 The frame length in cycles SHALL equal (1 + DATA_BITS + (PARITY≠PAR_NONE) + STOP_BITS) × CLKS_PER_BIT.

Reset
REQ-029 While rst=1, the block SHALL force uart_tx=1, ready=1, busy=0, overflow=0, fifo_count=0 and state=IDLE, and SHALL clear both pointers and the bit counters.
REQ-030 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously) and SHALL discard queued data; no partial frame SHALL resume after reset is released.
REQ-031 The first write may be accepted on the first rising edge after rst deasserts.

Structure
REQ-032 Package uart_pkg SHALL hold the parity_t enum (PAR_NONE, PAR_EVEN, PAR_ODD), the state_t enum, and the function clks_per_bit(clk_freq, baud).
REQ-033 The FIFO SHALL be the sub-module sync_fifo (parameters WIDTH and DEPTH; ports wr_en, rd_en, full, empty, count), reusable elsewhere in the codebase.
REQ-034 The serializer FSM, bit-period counter and shift register SHALL reside in uart_tx_fifo.

Verification
REQ-035 Defaults, send 0x48 ('H') once → uart_tx low from edge N+1 for 104 cycles, then 0,0,0,1,0,0,1,0 at 104 cycles each, then high; busy drops after 1040 cycles.
REQ-036 PARITY=PAR_EVEN, send 0x69 ('i') → parity bit 0, frame 1144 cycles; with PARITY=PAR_ODD → parity bit 1.
REQ-037 Defaults, 18 writes on consecutive cycles → 17 accepted, ready=0 after the 17th, overflow pulses once for the 18th, and 17 frames emerge back-to-back with no idle gap, in order.
REQ-038 Write and pop on the same edge with fifo_count=5 → fifo_count stays 5.
REQ-039 Reset asserted 300 cycles into a frame with 3 words queued → uart_tx=1 immediately, fifo_count=0, and no further frames after reset is released.
REQ-040 DATA_BITS=7, STOP_BITS=2, send 0x41 → 7 data bits then 208 high cycles; total frame 1040 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types: parity selection, serializer states and baud-divisor helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  // Prefixed so the PARITY state never collides with a PARITY parameter.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Clock cycles per line bit, rounded to the nearest integer.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is shown combinationally
// from the head entry so a pop can capture it on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array.
  always_ff @(posedge clk) begin
    // NOTE: the memory is deliberately not reset; the count and pointers define which entries are valid.
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: writes queue into a FIFO, a serializer pops words
// and sends start, data (LSB first), optional parity and stop bits back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ   = 12_000_000,
  parameter int      BAUD       = 115_200,
  parameter int      DATA_BITS  = 8,
  parameter parity_t PARITY     = PAR_NONE,
  parameter int      STOP_BITS  = 1,
  parameter int      FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          send,
  output logic                          ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      baud_cnt_q, baud_cnt_d;
  logic [3:0]            bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  ovf_q;

  logic                  fifo_push, fifo_pop;
  logic                  fifo_full, fifo_empty;
  logic [DATA_BITS-1:0]  fifo_rd_data;
  logic                  bit_done, start_frame;

  // ready comes from the registered count, so a full FIFO refuses a write even on a pop edge.
  assign fifo_push  = send & ~fifo_full;
  assign ready      = ~fifo_full;
  assign uart_tx    = tx_q;
  assign busy       = (state_q != ST_IDLE) | ~fifo_empty;
  assign overflow   = ovf_q;
  assign bit_done   = (baud_cnt_q == '0);

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_push),
    .wr_data (data),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Serializer: bit-period countdown, frame sequencing and pop of the next word.
  always_comb begin
    state_d     = state_q;
    baud_cnt_d  = baud_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tx_d        = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;

    if (state_q != ST_IDLE && !bit_done) baud_cnt_d = baud_cnt_q - CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (bit_done) begin
          state_d    = ST_DATA;
          tx_d       = shift_q[0];
          shift_d    = shift_q >> 1;
          bit_idx_d  = '0;
          baud_cnt_d = BIT_LAST;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_d = BIT_LAST;
          if (bit_idx_q == DATA_LAST) begin
            bit_idx_d = '0;
            if (PARITY != PAR_NONE) begin
              state_d = ST_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          bit_idx_d  = '0;
          baud_cnt_d = BIT_LAST;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          if (bit_idx_q == STOP_LAST) begin
            if (!fifo_empty) begin
              start_frame = 1'b1;
            end else begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d  = bit_idx_q + 4'd1;
            baud_cnt_d = BIT_LAST;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Pop the head word and drive the start bit on this same edge.
    if (start_frame) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_rd_data;
      par_d      = (^fifo_rd_data) ^ (PARITY == PAR_ODD);
      state_d    = ST_START;
      tx_d       = 1'b0;
      baud_cnt_d = BIT_LAST;
    end
  end

  // Serializer registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      ovf_q      <= send & fifo_full;
    end
  end

endmodule
